// File: rtl/exe_pkg.sv
// Shared types and constants for the RV32I execute stage.
package exe_pkg;

  // ALUOp encodings driven by the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam int         MUL_ITERATIONS = 32;

  typedef enum logic [3:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

  // Map ALUOp/funct fields onto a concrete ALU operation.
  // I-type arithmetic never subtracts (funct7 bits there belong to the
  // immediate); funct7[5] only selects SRA for shifts.
  function automatic alu_op_e decode_alu(input logic [1:0] alu_op,
                                         input logic [2:0] funct3,
                                         input logic [6:0] funct7);
    alu_op_e op;
    op = ADD;
    if (alu_op == ALUOP_ADD) begin
      op = ADD;
    end else if (alu_op == ALUOP_SUB) begin
      op = SUB;
    end else begin
      case (funct3)
        3'b000: begin
          if (alu_op == ALUOP_RTYPE && funct7 == FUNCT7_MULDIV) op = MUL;
          else if (alu_op == ALUOP_RTYPE && funct7[5])          op = SUB;
          else                                                  op = ADD;
        end
        3'b001:  op = SLL;
        3'b010:  op = SLT;
        3'b011:  op = SLTU;
        3'b100:  op = XOR;
        3'b101:  op = funct7[5] ? SRA : SRL;
        3'b110:  op = OR;
        default: op = AND;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Built only when RV32M_MUL_EN is defined. Keeps the low WIDTH bits.
module seq_multiplier
  import exe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int              CNT_W     = $clog2(MUL_ITERATIONS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITERATIONS - 1);

  mul_state_e       r_state, w_next_state;
  logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
  logic [CNT_W-1:0] r_count;

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!reset_i) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic; abort always wins
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal unassigned (latch).
    w_next_state = r_state;
    if (abort) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_next_state = BUSY;
        BUSY:    if (r_count == LAST_ITER) w_next_state = DONE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Datapath: load operands on start, then one shift-add step per BUSY cycle
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (r_state == IDLE && start && !abort) begin
      r_acc    <= '0;
      r_mcand  <= a;
      r_mplier <= b;
      r_count  <= '0;
    end else if (r_state == BUSY && !abort) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
    end
  end

  assign busy    = (r_state == BUSY);
  assign done    = (r_state == DONE);
  assign product = r_acc;

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage RV32I pipeline plus the EX/MEM register.
// Define RV32M_MUL_EN to build the multi-cycle MUL; otherwise MUL is
// treated as an illegal op and forwarded as a bubble.
module execute_stage
  import exe_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic                      RegWrite_EXECUTE,
  input  logic                      MemtoReg_EXECUTE,
  input  logic                      MemWrite_EXECUTE,
  input  logic                      MemRead_EXECUTE,
  input  logic                      Branch_EXECUTE,
  input  logic                      ALUSrc_EXECUTE,
  input  logic [1:0]                ALUOp_EXECUTE,
  input  logic [2:0]                Funct3_EXECUTE,
  input  logic [6:0]                Funct7_EXECUTE,
  input  logic [DATA_WIDTH-1:0]     PC_EXECUTE,
  input  logic [DATA_WIDTH-1:0]     ReadData1_EXECUTE,
  input  logic [DATA_WIDTH-1:0]     ReadData2_EXECUTE,
  input  logic [DATA_WIDTH-1:0]     Immediate_EXECUTE,
  input  logic [REG_ADDR_WIDTH-1:0] Write_Register_EXECUTE,
  output logic                      stall_o,
  output logic                      RegWrite_MEMORYACCESS,
  output logic                      MemtoReg_MEMORYACCESS,
  output logic                      MemWrite_MEMORYACCESS,
  output logic                      MemRead_MEMORYACCESS,
  output logic                      Branch_MEMORYACCESS,
  output logic [REG_ADDR_WIDTH-1:0] Write_Register_MEMORYACCESS,
  output logic [DATA_WIDTH-1:0]     Address_MEMORYACCESS,
  output logic [DATA_WIDTH-1:0]     WriteData_DataMemory_MEMORYACCESS,
  output logic                      zero_MEMORYACCESS,
  output logic [DATA_WIDTH-1:0]     BranchTarget_MEMORYACCESS
);

  logic [DATA_WIDTH-1:0] w_op_b, w_alu_result, w_result;
  logic [4:0]            w_shamt;
  alu_op_e               w_alu_op;
  logic                  w_is_mul, w_bubble;

  assign w_op_b   = ALUSrc_EXECUTE ? Immediate_EXECUTE : ReadData2_EXECUTE;
  assign w_shamt  = w_op_b[4:0];
  assign w_alu_op = decode_alu(ALUOp_EXECUTE, Funct3_EXECUTE, Funct7_EXECUTE);
  assign w_is_mul = (w_alu_op == MUL);

  // Single-cycle ALU; MUL result comes from the sequential multiplier
  always_comb begin
    w_alu_result = '0;
    case (w_alu_op)
      ADD:  w_alu_result = ReadData1_EXECUTE + w_op_b;
      SUB:  w_alu_result = ReadData1_EXECUTE - w_op_b;
      SLL:  w_alu_result = ReadData1_EXECUTE << w_shamt;
      SLT:  w_alu_result = {{(DATA_WIDTH-1){1'b0}},
                            ($signed(ReadData1_EXECUTE) < $signed(w_op_b))};
      SLTU: w_alu_result = {{(DATA_WIDTH-1){1'b0}}, (ReadData1_EXECUTE < w_op_b)};
      XOR:  w_alu_result = ReadData1_EXECUTE ^ w_op_b;
      SRL:  w_alu_result = ReadData1_EXECUTE >> w_shamt;
      SRA:  w_alu_result = $unsigned($signed(ReadData1_EXECUTE) >>> w_shamt);
      OR:   w_alu_result = ReadData1_EXECUTE | w_op_b;
      AND:  w_alu_result = ReadData1_EXECUTE & w_op_b;
      default: w_alu_result = '0;
    endcase
  end

`ifdef RV32M_MUL_EN
  logic                  w_mul_busy, w_mul_done;
  logic [DATA_WIDTH-1:0] w_product;

  seq_multiplier #(.WIDTH(DATA_WIDTH)) u_mul (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start   (w_is_mul),
    .abort   (flush_i),
    .a       (ReadData1_EXECUTE),
    .b       (w_op_b),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_product)
  );

  // Hold ID/EX from MUL arrival until the cycle the product is ready
  assign stall_o  = reset_i & ~flush_i & (w_mul_busy | (w_is_mul & ~w_mul_done));
  assign w_bubble = flush_i | stall_o;
  assign w_result = w_is_mul ? w_product : w_alu_result;
`else
  assign stall_o  = 1'b0;
  assign w_bubble = flush_i | w_is_mul;
  assign w_result = w_alu_result;
`endif

  // EX/MEM register: reset and bubbles both clear every field
  always_ff @(posedge clk_i) begin
    if (!reset_i || w_bubble) begin
      RegWrite_MEMORYACCESS             <= 1'b0;
      MemtoReg_MEMORYACCESS             <= 1'b0;
      MemWrite_MEMORYACCESS             <= 1'b0;
      MemRead_MEMORYACCESS              <= 1'b0;
      Branch_MEMORYACCESS               <= 1'b0;
      Write_Register_MEMORYACCESS       <= '0;
      Address_MEMORYACCESS              <= '0;
      WriteData_DataMemory_MEMORYACCESS <= '0;
      zero_MEMORYACCESS                 <= 1'b0;
      BranchTarget_MEMORYACCESS         <= '0;
    end else begin
      RegWrite_MEMORYACCESS             <= RegWrite_EXECUTE;
      MemtoReg_MEMORYACCESS             <= MemtoReg_EXECUTE;
      MemWrite_MEMORYACCESS             <= MemWrite_EXECUTE;
      MemRead_MEMORYACCESS              <= MemRead_EXECUTE;
      Branch_MEMORYACCESS               <= Branch_EXECUTE;
      Write_Register_MEMORYACCESS       <= Write_Register_EXECUTE;
      Address_MEMORYACCESS              <= w_result;
      WriteData_DataMemory_MEMORYACCESS <= ReadData2_EXECUTE;
      zero_MEMORYACCESS                 <= (w_result == '0);
      BranchTarget_MEMORYACCESS         <= PC_EXECUTE + Immediate_EXECUTE;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed scoreboard bench for execute_stage. MUL expectations follow
// RV32M_MUL_EN: with it, the 33-cycle stall sequence; without it, a bubble.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        rw_ex = 0, m2r_ex = 0, mw_ex = 0, mr_ex = 0, br_ex = 0, alusrc_ex = 0;
  logic [1:0]  aluop_ex = '0;
  logic [2:0]  f3_ex = '0;
  logic [6:0]  f7_ex = '0;
  logic [31:0] pc_ex = '0, rs1_ex = '0, rs2_ex = '0, imm_ex = '0;
  logic [4:0]  rd_ex = '0;

  logic        stall;
  logic        rw_mem, m2r_mem, mw_mem, mr_mem, br_mem, zero_mem;
  logic [4:0]  rd_mem;
  logic [31:0] addr_mem, wdata_mem, bt_mem;

  always #5 clk = ~clk;

  execute_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk_i                             (clk),
    .reset_i                           (reset_n),
    .flush_i                           (flush),
    .RegWrite_EXECUTE                  (rw_ex),
    .MemtoReg_EXECUTE                  (m2r_ex),
    .MemWrite_EXECUTE                  (mw_ex),
    .MemRead_EXECUTE                   (mr_ex),
    .Branch_EXECUTE                    (br_ex),
    .ALUSrc_EXECUTE                    (alusrc_ex),
    .ALUOp_EXECUTE                     (aluop_ex),
    .Funct3_EXECUTE                    (f3_ex),
    .Funct7_EXECUTE                    (f7_ex),
    .PC_EXECUTE                        (pc_ex),
    .ReadData1_EXECUTE                 (rs1_ex),
    .ReadData2_EXECUTE                 (rs2_ex),
    .Immediate_EXECUTE                 (imm_ex),
    .Write_Register_EXECUTE            (rd_ex),
    .stall_o                           (stall),
    .RegWrite_MEMORYACCESS             (rw_mem),
    .MemtoReg_MEMORYACCESS             (m2r_mem),
    .MemWrite_MEMORYACCESS             (mw_mem),
    .MemRead_MEMORYACCESS              (mr_mem),
    .Branch_MEMORYACCESS               (br_mem),
    .Write_Register_MEMORYACCESS       (rd_mem),
    .Address_MEMORYACCESS              (addr_mem),
    .WriteData_DataMemory_MEMORYACCESS (wdata_mem),
    .zero_MEMORYACCESS                 (zero_mem),
    .BranchTarget_MEMORYACCESS         (bt_mem)
  );

  // Control bundle order: {RegWrite, MemtoReg, MemWrite, MemRead, Branch}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_RW   = 5'b10000;
  localparam logic [4:0] C_LOAD = 5'b11010;
  localparam logic [4:0] C_ST   = 5'b00100;
  localparam logic [4:0] C_BR   = 5'b00001;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        zero;
    logic [31:0] bt;
  } exmem_t;

  typedef struct {
    exmem_t v;
    bit     bubble;
  } exp_t;

  exp_t   sb[$];
  exmem_t obs;
  int     n_checks = 0;
  int     n_errors = 0;

  assign obs = {rw_mem, m2r_mem, mw_mem, mr_mem, br_mem, rd_mem,
                addr_mem, wdata_mem, zero_mem, bt_mem};

  task automatic set_instr(input logic [1:0] aluop, input logic [2:0] f3,
                           input logic [6:0] f7, input logic alusrc,
                           input logic [31:0] pc, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm,
                           input logic [4:0] rd, input logic [4:0] ctrl);
    aluop_ex = aluop; f3_ex = f3; f7_ex = f7; alusrc_ex = alusrc;
    pc_ex = pc; rs1_ex = a; rs2_ex = b; imm_ex = imm; rd_ex = rd;
    {rw_ex, m2r_ex, mw_ex, mr_ex, br_ex} = ctrl;
  endtask

  task automatic push_full(input logic [4:0] ctrl, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic zero, input logic [31:0] bt);
    exp_t e;
    e.v = {ctrl, rd, addr, wdata, zero, bt};
    e.bubble = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    exp_t e;
    e.v = '0;
    e.bubble = 1'b1;
    sb.push_back(e);
  endtask

  task automatic check_stall(input string tag, input logic exp_stall);
    n_checks++;
    assert (stall === exp_stall) else begin
      n_errors++;
      $error("FAIL %s stall_o: got %b want %b", tag, stall, exp_stall);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $error("FAIL %s: no expected entry queued", tag);
      return;
    end
    e = sb.pop_front();
    if (e.bubble) begin
      assert ({rw_mem, mw_mem, mr_mem, br_mem} === 4'b0000) else begin
        n_errors++;
        $error("FAIL %s bubble ctrl(rw,mw,mr,br): got %b want 0000",
               tag, {rw_mem, mw_mem, mr_mem, br_mem});
      end
    end else begin
      assert (obs === e.v) else begin
        n_errors++;
        $error("FAIL %s: got ctrl=%b rd=%0d addr=%h wdata=%h zero=%b bt=%h want ctrl=%b rd=%0d addr=%h wdata=%h zero=%b bt=%h",
               tag, obs.ctrl, obs.rd, obs.addr, obs.wdata, obs.zero, obs.bt,
               e.v.ctrl, e.v.rd, e.v.addr, e.v.wdata, e.v.zero, e.v.bt);
      end
    end
  endtask

  // Check stall mid-cycle, then the EX/MEM contents just after the next edge
  task automatic step(input string tag, input logic exp_stall);
    #1;
    check_stall(tag, exp_stall);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    // Reset held with a live ADD in EX: everything must still read 0
    set_instr(2'b10, 3'b000, 7'h00, 1'b0, 32'h40, 32'd5, 32'd7, 32'd8, 5'd3, C_RW);
    @(posedge clk); #1;
    push_full(C_NONE, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    step("reset", 1'b0);
    reset_n = 1'b1;

    push_full(C_RW, 5'd3, 32'd12, 32'd7, 1'b0, 32'h48);
    step("add_r", 1'b0);

    set_instr(2'b01, 3'b000, 7'h00, 1'b0, 32'h100, 32'h10, 32'h10, 32'h20, 5'd0, C_BR);
    push_full(C_BR, 5'd0, 32'h0, 32'h10, 1'b1, 32'h120);
    step("beq", 1'b0);

    set_instr(2'b11, 3'b101, 7'h20, 1'b1, 32'h200, 32'h8000_0000, 32'h55, 32'd4, 5'd7, C_RW);
    push_full(C_RW, 5'd7, 32'hF800_0000, 32'h55, 1'b0, 32'h204);
    step("srai", 1'b0);

    set_instr(2'b10, 3'b011, 7'h00, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd8, C_RW);
    push_full(C_RW, 5'd8, 32'd0, 32'd1, 1'b1, 32'h0);
    step("sltu", 1'b0);

    f3_ex = 3'b010;
    push_full(C_RW, 5'd8, 32'd1, 32'd1, 1'b0, 32'h0);
    step("slt", 1'b0);

    set_instr(2'b10, 3'b000, 7'h20, 1'b0, 32'h0, 32'd10, 32'd3, 32'h0, 5'd9, C_RW);
    push_full(C_RW, 5'd9, 32'd7, 32'd3, 1'b0, 32'h0);
    step("sub_r", 1'b0);

    // I-type ADD ignores funct7[5] even when the immediate sets it
    set_instr(2'b11, 3'b000, 7'h7F, 1'b1, 32'h10, 32'd10, 32'h0, 32'hFFFF_FFFF, 5'd10, C_RW);
    push_full(C_RW, 5'd10, 32'd9, 32'h0, 1'b0, 32'hF);
    step("addi_neg", 1'b0);

    // Shift amount uses only operand B[4:0]: 0x21 shifts by 1
    set_instr(2'b11, 3'b001, 7'h00, 1'b1, 32'h0, 32'd3, 32'h0, 32'h21, 5'd4, C_RW);
    push_full(C_RW, 5'd4, 32'd6, 32'h0, 1'b0, 32'h21);
    step("slli_mask", 1'b0);

    set_instr(2'b10, 3'b101, 7'h00, 1'b0, 32'h0, 32'h8000_0000, 32'd4, 32'h0, 5'd4, C_RW);
    push_full(C_RW, 5'd4, 32'h0800_0000, 32'd4, 1'b0, 32'h0);
    step("srl", 1'b0);

    set_instr(2'b10, 3'b100, 7'h00, 1'b0, 32'h0, 32'hF0F0, 32'h0FF0, 32'h0, 5'd2, C_RW);
    push_full(C_RW, 5'd2, 32'hFF00, 32'h0FF0, 1'b0, 32'h0);
    step("xor", 1'b0);

    set_instr(2'b10, 3'b110, 7'h00, 1'b0, 32'h0, 32'hF0, 32'h0F, 32'h0, 5'd2, C_RW);
    push_full(C_RW, 5'd2, 32'hFF, 32'h0F, 1'b0, 32'h0);
    step("or", 1'b0);

    set_instr(2'b10, 3'b111, 7'h00, 1'b0, 32'h0, 32'hF0, 32'h3C, 32'h0, 5'd2, C_RW);
    push_full(C_RW, 5'd2, 32'h30, 32'h3C, 1'b0, 32'h0);
    step("and", 1'b0);

    // Load-style ADD that wraps to zero
    set_instr(2'b00, 3'b010, 7'h00, 1'b1, 32'h300, 32'hFFFF_FFFF, 32'hAB, 32'd1, 5'd11, C_LOAD);
    push_full(C_LOAD, 5'd11, 32'h0, 32'hAB, 1'b1, 32'h301);
    step("load_wrap", 1'b0);

    set_instr(2'b00, 3'b010, 7'h00, 1'b1, 32'h0, 32'h1000, 32'hDEAD, 32'hFFFF_FFFC, 5'd0, C_ST);
    push_full(C_ST, 5'd0, 32'hFFC, 32'hDEAD, 1'b0, 32'hFFFF_FFFC);
    step("store", 1'b0);

    set_instr(2'b10, 3'b000, 7'h00, 1'b0, 32'h0, 32'd1, 32'd2, 32'h0, 5'd6, C_RW);
    flush = 1'b1;
    push_bubble();
    step("flush_add", 1'b0);
    flush = 1'b0;

`ifdef RV32M_MUL_EN
    // MUL 7 x 6: 33 stalled bubbles, product on the 34th edge
    set_instr(2'b10, 3'b000, 7'h01, 1'b0, 32'h0, 32'd7, 32'd6, 32'h0, 5'd5, C_RW);
    for (int i = 0; i < 33; i++) begin
      push_bubble();
      step($sformatf("mul1_stall_%0d", i), 1'b1);
    end
    push_full(C_RW, 5'd5, 32'd42, 32'd6, 1'b0, 32'h0);
    step("mul1_done", 1'b0);

    // Back-to-back MUL starts a fresh sequence
    set_instr(2'b10, 3'b000, 7'h01, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'd2, 32'h0, 5'd6, C_RW);
    for (int i = 0; i < 33; i++) begin
      push_bubble();
      step($sformatf("mul2_stall_%0d", i), 1'b1);
    end
    push_full(C_RW, 5'd6, 32'hFFFF_FFFE, 32'd2, 1'b0, 32'h0);
    step("mul2_done", 1'b0);

    // Flush in the 10th BUSY cycle kills the MUL
    set_instr(2'b10, 3'b000, 7'h01, 1'b0, 32'h0, 32'd3, 32'd3, 32'h0, 5'd12, C_RW);
    for (int i = 0; i < 10; i++) begin
      push_bubble();
      step($sformatf("mul3_stall_%0d", i), 1'b1);
    end
    flush = 1'b1;
    push_bubble();
    step("mul3_flush", 1'b0);
    flush = 1'b0;

    set_instr(2'b10, 3'b000, 7'h00, 1'b0, 32'h0, 32'd2, 32'd3, 32'h0, 5'd13, C_RW);
    push_full(C_RW, 5'd13, 32'd5, 32'd3, 1'b0, 32'h0);
    step("add_after_flush", 1'b0);

    // A full-length sequence afterwards shows the FSM restarted from IDLE
    set_instr(2'b10, 3'b000, 7'h01, 1'b0, 32'h0, 32'd3, 32'd3, 32'h0, 5'd12, C_RW);
    for (int i = 0; i < 33; i++) begin
      push_bubble();
      step($sformatf("mul4_stall_%0d", i), 1'b1);
    end
    push_full(C_RW, 5'd12, 32'd9, 32'd3, 1'b0, 32'h0);
    step("mul4_done", 1'b0);

    // Reset in the middle of a MUL
    set_instr(2'b10, 3'b000, 7'h01, 1'b0, 32'h0, 32'd7, 32'd6, 32'h0, 5'd5, C_RW);
    for (int i = 0; i < 5; i++) begin
      push_bubble();
      step($sformatf("mul5_stall_%0d", i), 1'b1);
    end
`else
    // Without the M option a MUL is an illegal op: bubble, never stalls
    set_instr(2'b10, 3'b000, 7'h01, 1'b0, 32'h0, 32'd7, 32'd6, 32'h0, 5'd5, C_RW);
    push_bubble();
    step("mul_illegal", 1'b0);
    set_instr(2'b10, 3'b000, 7'h00, 1'b0, 32'h0, 32'd7, 32'd6, 32'h0, 5'd5, C_RW);
    push_full(C_RW, 5'd5, 32'd13, 32'd6, 1'b0, 32'h0);
    step("add_after_illegal", 1'b0);
    set_instr(2'b10, 3'b000, 7'h01, 1'b0, 32'h0, 32'd7, 32'd6, 32'h0, 5'd5, C_RW);
`endif
    reset_n = 1'b0;
    push_full(C_NONE, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    step("reset_mid", 1'b0);
    reset_n = 1'b1;

    set_instr(2'b10, 3'b000, 7'h00, 1'b0, 32'h0, 32'd1, 32'd1, 32'h0, 5'd1, C_RW);
    push_full(C_RW, 5'd1, 32'd2, 32'd1, 1'b0, 32'h0);
    step("add_after_reset", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
